muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
EX-stage controller that sits upstream of the multi-cycle multiplier and divider and consumes their results.
- Decodes HI/LO-class ops from EX and drives the start/operand handshake to the selected unit.
- Stalls the pipeline while a unit is busy and writes the 64-bit result into the architectural HI/LO registers.
- Handles MTHI/MTLO directly and enforces a release phase so a unit is never restarted before it has returned to its free state.

Parameters:
OP_W, 4, width of op_i encoding
HILO_RESET, 64'h0, reset value of {HI,LO}

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid_i  in  1  EX holds a valid instruction
op_i  in  OP_W  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NOP
rs_i  in  32  operand 1 / MTHI/MTLO source
rt_i  in  32  operand 2
flush_i  in  1  exception flush of EX
mult_start_o  out  1  multiplier start (held until result taken)
mult_signed_o  out  1  signed multiply
mult_op1_o, mult_op2_o  out  32 each  latched operands
mult_ready_i  in  1  multiplier result valid
mult_result_i  in  64  product {hi,lo}
div_start_o  out  1  divider start
div_signed_o  out  1  signed divide
div_op1_o, div_op2_o  out  32 each  dividend, divisor
div_ready_i  in  1  divider result valid
div_result_i  in  64  {remainder,quotient}
stall_o  out  1  hold EX and earlier stages
hi_o, lo_o  out  32 each  architectural HI, LO (registered)

Behaviour:
- Reset: clk, with rst synchronous active-high.
  - State IDLE; all start/signed outputs 0; operand outputs 0.
  - {hi_o,lo_o}=HILO_RESET; discard=0; sel=MUL.
  - Reset mid-operation aborts immediately; both units share rst.
- go = ex_valid_i & !flush_i. mdop = op in {1,2,3,4} (plus 7..10 when the feature is enabled).
- IDLE:
  - go & mdop: latch rs/rt into the selected unit's op1/op2. Set signed = (op is MULT/DIV/MADD/MSUB). Record sel, kind and op. Set that unit's start=1 at the edge. Go to BUSY.
  - stall_o=1 combinationally in that cycle.
  - go & MTHI: hi<=rs_i; go & MTLO: lo<=rs_i. No stall; written at the same edge.
  - flush_i suppresses every write and start.
- BUSY:
  - Start held at 1. stall_o = !ready_sel, where ready_sel is the selected unit's ready.
  - flush_i in BUSY sets discard=1 (sticky). The unit is always drained, never abandoned.
  - On ready_sel=1:
    - If !discard: MUL/DIV → {hi,lo} <= result_i[63:0]. For DIV, HI=remainder and LO=quotient.
    - Start <= 0; discard <= 0; go to RELEASE.
    - stall_o=0 in that cycle, so the instruction leaves EX at the same edge HI/LO update. The next instruction's MFHI/MFLO sees the new value.
- RELEASE:
  - Start=0. Wait for ready_sel=0, then go to IDLE.
  - stall_o = go & mdop (a new mul/div waits for IDLE). MTHI/MTLO are accepted as in IDLE.
- Only one unit is active at a time. The other unit's ready/result are ignored.
- Arithmetic: the result is passed through; divide-by-zero behaviour is the divider's, and HI/LO take whatever it returns.
- The start pulse is never reasserted while the unit's ready is high. This guarantees the unit has returned to free before a new start.

Optional Feature:
HILO_MADD_EN
- Defined:
  - ops 7..10 use the multiplier (MADD/MSUB signed, MADDU/MSUBU unsigned).
  - On ready: {hi,lo} <= {hi,lo} + product for MADD/MADDU, {hi,lo} <= {hi,lo} - product for MSUB/MSUBU, 64-bit wrap.
  - The add/subtract uses the HI/LO value at capture time.
- Undefined: ops 7..10 are NOP (no stall, no write).

Test Plan:
- MULT rs=FFFFFFFD rt=00000005, multiplier model ready 5 cycles after start → stall high until ready cycle, hi=FFFFFFFF lo=FFFFFFF1, start low next cycle.
- MULTU rs=FFFFFFFF rt=2 then DIVU rs=7 rt=2 back-to-back → second op stalls through RELEASE until mult_ready falls. Then hi=1 lo=FFFFFFFE, followed by hi=1 lo=3.
- MTHI 12345678 then MTLO 9ABCDEF0 with no stall → hi_o/lo_o update on each edge. flush_i high with MTLO → lo unchanged.
- DIV rs=FFFFFFF9(-7) rt=2, flush_i pulsed 2 cycles after start → start held until ready, HI/LO unchanged, then RELEASE→IDLE.
- rst asserted while BUSY → next cycle start=0, stall=0, {hi,lo}=0. A fresh MULT 3×4 then completes with lo=C hi=0.
- HILO_MADD_EN: hi=0 lo=FFFFFFFF, MADDU 1×1 → hi=1 lo=0. MSUB 2×3 → hi=0 lo=FFFFFFFA.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: EX-stage controller for the multi-cycle multiplier and divider.
// Decodes HI/LO-class ops, runs the start/ready handshake with the selected
// unit, stalls EX while the unit works and writes its 64-bit result into the
// architectural HI/LO registers. MTHI/MTLO are handled directly. After every
// operation a RELEASE phase waits for the unit's ready to fall before a new
// start can be issued.
//
// Optional feature macro: HILO_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into HI/LO).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid_i, op_i, rs_i, rt_i  EX instruction, op code and operands
//   flush_i                       exception flush of EX
//   mult_start_o/signed_o/op1_o/op2_o, mult_ready_i, mult_result_i  multiplier handshake
//   div_start_o/signed_o/op1_o/op2_o,  div_ready_i,  div_result_i   divider handshake
//   stall_o                       hold EX and earlier stages (combinational)
//   hi_o, lo_o                    architectural HI and LO (registered)
module muldiv_hilo_ctrl #(
    parameter int unsigned OP_W       = 4,
    parameter logic [63:0] HILO_RESET = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [31:0]     rs_i,
    input  logic [31:0]     rt_i,
    input  logic            flush_i,
    output logic            mult_start_o,
    output logic            mult_signed_o,
    output logic [31:0]     mult_op1_o,
    output logic [31:0]     mult_op2_o,
    input  logic            mult_ready_i,
    input  logic [63:0]     mult_result_i,
    output logic            div_start_o,
    output logic            div_signed_o,
    output logic [31:0]     div_op1_o,
    output logic [31:0]     div_op2_o,
    input  logic            div_ready_i,
    input  logic [63:0]     div_result_i,
    output logic            stall_o,
    output logic [31:0]     hi_o,
    output logic [31:0]     lo_o
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWORD_W = 64;

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(6);
`ifdef HILO_MADD_EN
    localparam logic [OP_W-1:0] OP_MADD  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MADDU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_MSUB  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MSUBU = OP_W'(10);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;
    typedef enum logic {SEL_MUL, SEL_DIV} sel_t;
    typedef enum logic [1:0] {KIND_SET, KIND_ADD, KIND_SUB} kind_t;

    state_t              state_q, state_d;
    sel_t                sel_q, sel_d;
    kind_t               kind_q, kind_d;
    logic                discard_q, discard_d;
    logic                mult_start_d, mult_signed_d, div_start_d, div_signed_d;
    logic [WORD_W-1:0]   mult_op1_d, mult_op2_d, div_op1_d, div_op2_d;
    logic [WORD_W-1:0]   hi_d, lo_d;
    logic                stall_c;

    logic                is_mul, is_div, is_sgn, is_mthi, is_mtlo;
    kind_t               dec_kind;
    logic                go, mdop, ready_sel;
    logic [DWORD_W-1:0]  result_sel, hilo_next;

    // Op decode
    always_comb begin
        is_mul   = 1'b0;
        is_div   = 1'b0;
        is_sgn   = 1'b0;
        is_mthi  = 1'b0;
        is_mtlo  = 1'b0;
        dec_kind = KIND_SET;
        case (op_i)
            OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef HILO_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_sgn = 1'b1; dec_kind = KIND_ADD; end
            OP_MADDU: begin is_mul = 1'b1; dec_kind = KIND_ADD; end
            OP_MSUB:  begin is_mul = 1'b1; is_sgn = 1'b1; dec_kind = KIND_SUB; end
            OP_MSUBU: begin is_mul = 1'b1; dec_kind = KIND_SUB; end
`endif
            default: ;
        endcase
    end

    assign go        = ex_valid_i & ~flush_i;
    assign mdop      = is_mul | is_div;
    assign ready_sel = (sel_q == SEL_DIV) ? div_ready_i : mult_ready_i;
    assign result_sel = (sel_q == SEL_DIV) ? div_result_i : mult_result_i;

    // Accumulating ops use HI/LO as it stands on the ready edge
    always_comb begin
        case (kind_q)
            KIND_ADD: hilo_next = {hi_o, lo_o} + result_sel;
            KIND_SUB: hilo_next = {hi_o, lo_o} - result_sel;
            default:  hilo_next = result_sel;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        kind_d        = kind_q;
        discard_d     = discard_q;
        mult_start_d  = mult_start_o;
        mult_signed_d = mult_signed_o;
        mult_op1_d    = mult_op1_o;
        mult_op2_d    = mult_op2_o;
        div_start_d   = div_start_o;
        div_signed_d  = div_signed_o;
        div_op1_d     = div_op1_o;
        div_op2_d     = div_op2_o;
        hi_d          = hi_o;
        lo_d          = lo_o;
        stall_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go && mdop) begin
                    stall_c = 1'b1;
                    state_d = ST_BUSY;
                    kind_d  = dec_kind;
                    if (is_div) begin
                        sel_d        = SEL_DIV;
                        div_start_d  = 1'b1;
                        div_signed_d = is_sgn;
                        div_op1_d    = rs_i;
                        div_op2_d    = rt_i;
                    end else begin
                        sel_d         = SEL_MUL;
                        mult_start_d  = 1'b1;
                        mult_signed_d = is_sgn;
                        mult_op1_d    = rs_i;
                        mult_op2_d    = rt_i;
                    end
                end else if (go && is_mthi) begin
                    hi_d = rs_i;
                end else if (go && is_mtlo) begin
                    lo_d = rs_i;
                end
            end

            ST_BUSY: begin
                // The unit is always drained; a flush only drops the write-back
                stall_c = ~ready_sel;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (ready_sel) begin
                    if (!(discard_q || flush_i)) begin
                        {hi_d, lo_d} = hilo_next;
                    end
                    mult_start_d = 1'b0;
                    div_start_d  = 1'b0;
                    discard_d    = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // New mul/div waits until the unit has dropped ready
                stall_c = go & mdop;
                if (!ready_sel) begin
                    state_d = ST_IDLE;
                end
                if (go && is_mthi) begin
                    hi_d = rs_i;
                end else if (go && is_mtlo) begin
                    lo_d = rs_i;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= SEL_MUL;
            kind_q        <= KIND_SET;
            discard_q     <= 1'b0;
            mult_start_o  <= 1'b0;
            mult_signed_o <= 1'b0;
            mult_op1_o    <= '0;
            mult_op2_o    <= '0;
            div_start_o   <= 1'b0;
            div_signed_o  <= 1'b0;
            div_op1_o     <= '0;
            div_op2_o     <= '0;
            hi_o          <= HILO_RESET[63:32];
            lo_o          <= HILO_RESET[31:0];
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            kind_q        <= kind_d;
            discard_q     <= discard_d;
            mult_start_o  <= mult_start_d;
            mult_signed_o <= mult_signed_d;
            mult_op1_o    <= mult_op1_d;
            mult_op2_o    <= mult_op2_d;
            div_start_o   <= div_start_d;
            div_signed_o  <= div_signed_d;
            div_op1_o     <= div_op1_d;
            div_op2_o     <= div_op2_d;
            hi_o          <= hi_d;
            lo_o          <= lo_d;
        end
    end

    assign stall_o = stall_c;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: self-checking bench for muldiv_hilo_ctrl with simple
// multiplier/divider models (fixed latency, ready lingers after start drops).
// Build with +define+HILO_MADD_EN to cover the accumulate ops.
module tb_muldiv_hilo_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 4;
    localparam int HOLD    = 2;
    localparam int WAIT_MAX = 60;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        flush;
    logic        mult_start_o, mult_signed_o;
    logic [31:0] mult_op1_o, mult_op2_o;
    logic        mult_ready;
    logic [63:0] mult_result;
    logic        div_start_o, div_signed_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic        div_ready;
    logic [63:0] div_result;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;

    int vectors = 0;
    int errors  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.OP_W(4), .HILO_RESET(64'h0)) dut (
        .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .op_i(op), .rs_i(rs), .rt_i(rt),
        .flush_i(flush),
        .mult_start_o(mult_start_o), .mult_signed_o(mult_signed_o),
        .mult_op1_o(mult_op1_o), .mult_op2_o(mult_op2_o),
        .mult_ready_i(mult_ready), .mult_result_i(mult_result),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_ready_i(div_ready), .div_result_i(div_result),
        .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Multiplier model: ready MUL_LAT cycles after start, drops HOLD cycles after start falls
    int m_cnt, m_hold;
    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 0; m_hold <= 0; mult_ready <= 1'b0; mult_result <= 64'h0;
        end else if (mult_start_o && !mult_ready) begin
            if (m_cnt == MUL_LAT - 1) begin
                m_cnt <= 0;
                mult_ready <= 1'b1;
                mult_result <= mul64(mult_op1_o, mult_op2_o, mult_signed_o);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (!mult_start_o && mult_ready) begin
            if (m_hold == HOLD - 1) begin
                m_hold <= 0; mult_ready <= 1'b0;
            end else begin
                m_hold <= m_hold + 1;
            end
        end
    end

    // Divider model, same handshake shape
    int d_cnt, d_hold;
    always @(posedge clk) begin
        if (rst) begin
            d_cnt <= 0; d_hold <= 0; div_ready <= 1'b0; div_result <= 64'h0;
        end else if (div_start_o && !div_ready) begin
            if (d_cnt == DIV_LAT - 1) begin
                d_cnt <= 0;
                div_ready <= 1'b1;
                div_result <= div64(div_op1_o, div_op2_o, div_signed_o);
            end else begin
                d_cnt <= d_cnt + 1;
            end
        end else if (!div_start_o && div_ready) begin
            if (d_hold == HOLD - 1) begin
                d_hold <= 0; div_ready <= 1'b0;
            end else begin
                d_hold <= d_hold + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // A start must never rise while that unit still reports ready
    logic m_start_prev = 1'b0;
    logic d_start_prev = 1'b0;
    always @(negedge clk) begin
        if (mult_start_o === 1'b1 && !m_start_prev) check("mult_start_rise_ready", 64'(mult_ready), 64'd0);
        if (div_start_o === 1'b1 && !d_start_prev) check("div_start_rise_ready", 64'(div_ready), 64'd0);
        m_start_prev = (mult_start_o === 1'b1);
        d_start_prev = (div_start_o === 1'b1);
    end

    task automatic check_hilo(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            check(tag, {hi_o, lo_o}, exp_q.pop_front());
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; op = o; rs = a; rt = b; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0; op = OP_NOP; flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles; returns at the negedge of the first unstalled cycle
    task automatic wait_stall_low(input string tag, output int n);
        n = 0;
        @(negedge clk);
        while (stall_o !== 1'b0 && n < WAIT_MAX) begin
            n++;
            @(negedge clk);
        end
        if (n >= WAIT_MAX) check({tag, "_timeout"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; ex_valid = 1'b0; op = OP_NOP; rs = '0; rt = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(64'h0);
        check_hilo("reset_hilo");
        check("reset_mult_start", 64'(mult_start_o), 64'd0);
        check("reset_div_start", 64'(div_start_o), 64'd0);
        check("reset_ops", {mult_op1_o, div_op2_o}, 64'h0);
        check("reset_signed", {62'd0, mult_signed_o, div_signed_o}, 64'd0);
        rst = 1'b0;
        idle(2);

        // MULT -3 * 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        check("mult_issue_stall", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        check("mult_start_set", 64'(mult_start_o), 64'd1);
        check("mult_signed", 64'(mult_signed_o), 64'd1);
        check("mult_operands", {mult_op1_o, mult_op2_o}, 64'hFFFF_FFFD_0000_0005);
        wait_stall_low("mult", n);
        check("mult_busy_stall_cycles", 64'(n), 64'd5);
        @(posedge clk); #1;
        check_hilo("mult_result");
        check("mult_start_dropped", 64'(mult_start_o), 64'd0);
        idle(4);

        // MULTU then DIVU back-to-back
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        exp_q.push_back(64'h0000_0001_FFFF_FFFE);
        wait_stall_low("multu", n);
        check("multu_stall_cycles", 64'(n), 64'd6);
        @(posedge clk); #1;
        check_hilo("multu_result");
        issue(OP_DIVU, 32'h0000_0007, 32'h0000_0002);
        exp_q.push_back(64'h0000_0001_0000_0003);
        wait_stall_low("divu", n);
        check("divu_stall_cycles", 64'(n), 64'd8);
        @(posedge clk); #1;
        check_hilo("divu_result");
        check("divu_operands", {div_op1_o, div_op2_o}, 64'h0000_0007_0000_0002);
        check("divu_unsigned", 64'(div_signed_o), 64'd0);

        // MTHI / MTLO (first one lands while still in RELEASE)
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        exp_q.push_back(64'h1234_5678_0000_0003);
        @(negedge clk);
        check("mthi_no_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        check_hilo("mthi");
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        check_hilo("mtlo");
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'h0);
        flush = 1'b1;
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        check_hilo("mtlo_flushed");
        idle(4);

        // MULT with flush in IDLE: no start
        issue(OP_MULT, 32'h1, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        check("flushed_mult_no_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        check("flushed_mult_no_start", 64'(mult_start_o), 64'd0);
        idle(2);

        // DIV -7 / 2 flushed mid-flight: drained, result dropped
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        @(posedge clk); #1;
        check("div_start_set", 64'(div_start_o), 64'd1);
        check("div_signed", 64'(div_signed_o), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0;
        check("div_start_held", 64'(div_start_o), 64'd1);
        wait_stall_low("div_flush", n);
        @(posedge clk); #1;
        check_hilo("div_discarded");
        check("div_start_dropped", 64'(div_start_o), 64'd0);
        idle(4);

        // Reset while BUSY
        issue(OP_MULT, 32'h5, 32'h6);
        @(posedge clk); #1;
        check("rst_mult_started", 64'(mult_start_o), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_start", 64'(mult_start_o), 64'd0);
        check("rst_busy_stall", 64'(stall_o), 64'd0);
        exp_q.push_back(64'h0);
        check_hilo("rst_busy_hilo");
        rst = 1'b0;
        issue(OP_MULT, 32'h3, 32'h4);
        exp_q.push_back(64'h0000_0000_0000_000C);
        wait_stall_low("mult_after_rst", n);
        @(posedge clk); #1;
        check_hilo("mult_after_rst");

        // Unused op codes are NOPs
        issue(4'd11, 32'h1, 32'h1);
        @(negedge clk);
        check("op11_no_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;

`ifdef HILO_MADD_EN
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        exp_q.push_back(64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #1;
        check_hilo("madd_setup");
        issue(OP_MADDU, 32'h1, 32'h1);
        exp_q.push_back(64'h0000_0001_0000_0000);
        wait_stall_low("maddu", n);
        @(posedge clk); #1;
        check_hilo("maddu_result");
        issue(OP_MSUB, 32'h2, 32'h3);
        exp_q.push_back(64'h0000_0000_FFFF_FFFA);
        wait_stall_low("msub", n);
        @(posedge clk); #1;
        check_hilo("msub_result");
        check("msub_signed", 64'(mult_signed_o), 64'd1);
`else
        issue(OP_MADD, 32'h1, 32'h1);
        exp_q.push_back(64'h0000_0000_0000_000C);
        @(negedge clk);
        check("madd_nop_no_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        check("madd_nop_no_start", 64'(mult_start_o), 64'd0);
        check_hilo("madd_nop_hilo");
`endif
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
